i2c_arbiter: RTL

Round-robin arbiter that shares the single I2C master (the `i2c` engine driving `scl_o`/`sda_io`) between NREQ independent requesters. Typical requesters are the ROM init sequencer, an HDMI hot-plug re-init sequencer and a UART-driven debug register port. The arbiter owns the master's `send`/`nbytes`/`data` inputs for the full life of one transaction. It returns read data and ACK status to the granted requester. A watchdog frees the bus if the master hangs.

---
 rtl/i2c_arbiter_pkg.sv | 22 ++
 rtl/i2c_arbiter_if.sv | 27 ++
 rtl/i2c_arbiter_rr_arbiter.sv | 40 ++++
 rtl/i2c_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/i2c_arbiter_pkg.sv
// rtl/i2c_arbiter_pkg.sv - shared types, constants and helpers for the I2C arbiter
package i2c_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_BUSY,
        ST_RELEASE,
        ST_RESP
    } i2c_arb_st_t;

    // Widest status vector supported; users slice it down to NBYTES bits.
    localparam logic [7:0] I2C_NACK_ALL = '1;

    function automatic int mclog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/i2c_arbiter_if.sv
// rtl/i2c_arbiter_if.sv - command/response bundle between the arbiter and the I2C master
interface i2c_arbiter_if
    import i2c_arbiter_pkg::*;
#(
    parameter int NBYTES = 2
);
    localparam int NBW = mclog2(NBYTES + 1);

    logic                      m_send_o;
    logic [NBW-1:0]            m_nbytes_o;
    logic [NBYTES*8-1:0]       m_data_o;
    logic                      m_done_i;
    logic                      m_ready_i;
    logic [(NBYTES-1)*8-1:0]   m_rdata_i;
    logic [NBYTES-1:0]         m_status_i;

    modport master (
        output m_send_o, m_nbytes_o, m_data_o,
        input  m_done_i, m_ready_i, m_rdata_i, m_status_i
    );

    modport slave (
        input  m_send_o, m_nbytes_o, m_data_o,
        output m_done_i, m_ready_i, m_rdata_i, m_status_i
    );

endinterface

// File: rtl/i2c_arbiter_rr_arbiter.sv
// rtl/i2c_arbiter_rr_arbiter.sv - round-robin grant selection with its rotating pointer
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [NREQ-1:0] req_i,
    input  logic            advance_i,
    input  logic [GW-1:0]   gidx_i,
    output logic [NREQ-1:0] grant_o
);

    logic [GW-1:0] r_ptr;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ptr <= '0;
        end else if (advance_i) begin
            r_ptr <= (gidx_i == GW'(NREQ - 1)) ? '0 : gidx_i + 1'b1;
        end
    end

    // Scan from the pointer upward, wrapping, and take the first request found.
    always_comb begin
        logic [GW:0] idx;
        logic        found;
        grant_o = '0;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, r_ptr} + (GW + 1)'(i);
            if (idx >= (GW + 1)'(NREQ)) idx = idx - (GW + 1)'(NREQ);
            if (!found && req_i[idx[GW-1:0]]) begin
                grant_o[idx[GW-1:0]] = 1'b1;
                found                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - shares one I2C master between NREQ requesters with a hang watchdog
module i2c_arbiter
    import i2c_arbiter_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int NBYTES  = 2,
    parameter int TIMEOUT = 1048576
) (
    input  logic                                       clk_i,
    input  logic                                       rst_n_i,
    input  logic [NREQ-1:0]                            req_valid_i,
    input  logic [NREQ-1:0][mclog2(NBYTES + 1)-1:0]    req_nbytes_i,
    input  logic [NREQ-1:0][NBYTES*8-1:0]              req_data_i,
    output logic [NREQ-1:0]                            req_ready_o,
    output logic [NREQ-1:0]                            rsp_valid_o,
    output logic [(NBYTES-1)*8-1:0]                    rsp_data_o,
    output logic [NBYTES-1:0]                          rsp_status_o,
    output logic                                       rsp_timeout_o,
    i2c_arbiter_if.master                              m
);

    localparam int NBW = mclog2(NBYTES + 1);
    localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [NBYTES-1:0] NACK = I2C_NACK_ALL[NBYTES-1:0];

    i2c_arb_st_t               r_state, w_state_nxt;
    logic [GW-1:0]             r_g;
    logic [NBW-1:0]            r_nbytes;
    logic [NBYTES*8-1:0]       r_data;
    logic [(NBYTES-1)*8-1:0]   r_rdata;
    logic [NBYTES-1:0]         r_status;
    logic                      r_timeout;
    logic [WDW-1:0]            r_wdog;

    logic [NREQ-1:0]           w_grant;
    logic [GW-1:0]             w_g_idx;
    logic [NBW-1:0]            w_nb;
    logic                      w_legal;
    logic                      w_accept;
    logic                      w_advance;
    logic                      w_abort;
    logic [WDW-1:0]            w_wdog_inc;
    logic                      w_wdog_exp;

    rr_arbiter #(.NREQ(NREQ), .GW(GW)) u_rr (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .req_i     (req_valid_i),
        .advance_i (w_advance),
        .gidx_i    (r_g),
        .grant_o   (w_grant)
    );

    always_comb begin
        w_g_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) w_g_idx = GW'(i);
        end
    end

    assign w_nb       = req_nbytes_i[w_g_idx];
    assign w_legal    = (w_nb != '0) && (w_nb <= NBW'(NBYTES));
    assign w_wdog_inc = r_wdog + 1'b1;
    assign w_wdog_exp = (w_wdog_inc >= WDW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // m_ready_i is ignored in BUSY: it may still be high from before the send.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_advance   = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (m.m_ready_i && (req_valid_i != '0)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_legal ? ST_SEND : ST_RESP;
                end
            end
            ST_SEND: w_state_nxt = ST_BUSY;
            ST_BUSY: begin
                if (m.m_done_i) begin
                    w_state_nxt = ST_RELEASE;
                end else if (w_wdog_exp) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RELEASE: begin
                if (m.m_ready_i) begin
                    w_state_nxt = ST_RESP;
                end else if (w_wdog_exp) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_advance   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_g       <= '0;
            r_nbytes  <= '0;
            r_data    <= '0;
            r_rdata   <= '0;
            r_status  <= '0;
            r_timeout <= 1'b0;
            r_wdog    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_g       <= w_g_idx;
                        r_nbytes  <= w_nb;
                        r_data    <= req_data_i[w_g_idx];
                        r_rdata   <= '0;
                        r_status  <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                ST_SEND: r_wdog <= '0;
                ST_BUSY, ST_RELEASE: begin
                    r_wdog <= w_wdog_inc;
                    if (r_state == ST_BUSY && m.m_done_i) begin
                        r_rdata  <= m.m_rdata_i;
                        r_status <= m.m_status_i;
                    end
                    if (w_abort) begin
                        r_timeout <= 1'b1;
                        r_status  <= NACK;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o   = w_accept ? w_grant : '0;
    assign rsp_valid_o   = (r_state == ST_RESP) ? (NREQ'(1) << r_g) : '0;
    assign rsp_data_o    = r_rdata;
    assign rsp_status_o  = r_status;
    assign rsp_timeout_o = r_timeout;
    assign m.m_send_o    = (r_state == ST_SEND);
    assign m.m_nbytes_o  = r_nbytes;
    assign m.m_data_o    = r_data;

endmodule
